sprite_rom_arbiter: RTL and testbench

Shares the single registered read port of one sprite ROM (8-bit data, one-cycle read latency, e.g. the digit/pin sprite ROMs) between two requesters in the pixel clock domain. Typical requesters are the score-digit overlay and the pin-screen renderer. Each requester asks for a burst of consecutive addresses, typically one sprite row. The block arbitrates, drives the ROM address, and returns the read data tagged to the requester with exact ROM-latency alignment.

---
 rtl/sprite_rom_arbiter_if.sv | 28 ++
 rtl/sprite_rom_arbiter.sv | 143 ++++++++++++++
 tb/tb_sprite_rom_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/sprite_rom_arbiter_if.sv
// Requester-side bus of the sprite ROM arbiter: burst requests, grants and tagged read-data return.
interface sprite_rom_arbiter_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 7
);
    logic [1:0]        req;
    logic [ADDR_W-1:0] start_addr0;
    logic [ADDR_W-1:0] start_addr1;
    logic [LEN_W-1:0]  len0;
    logic [LEN_W-1:0]  len1;
    logic [1:0]        gnt;
    logic              busy;
    logic [1:0]        rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    logic              err;

    modport master (
        output req, start_addr0, start_addr1, len0, len1,
        input  gnt, busy, rd_valid, rd_data, rd_last, err
    );

    modport slave (
        input  req, start_addr0, start_addr1, len0, len1,
        output gnt, busy, rd_valid, rd_data, rd_last, err
    );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Two-requester burst arbiter for a single registered-read sprite ROM port.
// Define SPRITE_ARB_RR_EN for round-robin tie-breaking; otherwise requester 0 has fixed priority.
module sprite_rom_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 6816,
    parameter int LEN_W  = 7
) (
    input  logic              clk_pix,
    input  logic              reset_n,
    sprite_rom_arbiter_if.slave bus,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);
    typedef enum logic {S_IDLE, S_BURST} state_t;

    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

    state_t            state_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W-1:0] rom_addr_reg;
    logic [LEN_W-1:0]  cnt_reg;
    logic              owner_reg;
    logic              oor_reg;
    logic              wrap_reg;
    logic [1:0]        rd_valid_reg;
    logic              rd_last_reg;
    logic              err_reg;
`ifdef SPRITE_ARB_RR_EN
    logic              last_gnt_reg;
`endif

    logic              any_req;
    logic              do_grant;
    logic              winner;
    logic [ADDR_W-1:0] sel_start;
    logic [LEN_W-1:0]  sel_len;
    logic [LEN_W-1:0]  sel_len_eff;
    logic [ADDR_W-1:0] inc_addr;
    logic              inc_carry;
    logic [ADDR_W-1:0] addr_next;
    logic              oor_next;

    function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} >= DEPTH_X;
    endfunction

    assign any_req  = |bus.req;
    assign do_grant = (state_reg == S_IDLE) && any_req;

    always_comb begin
`ifdef SPRITE_ARB_RR_EN
        winner = (bus.req == 2'b11) ? ~last_gnt_reg : ~bus.req[0];
`else
        winner = ~bus.req[0];
`endif
    end

    assign sel_start   = winner ? bus.start_addr1 : bus.start_addr0;
    assign sel_len     = winner ? bus.len1 : bus.len0;
    assign sel_len_eff = (sel_len == '0) ? LEN_W'(1) : sel_len;

    // The carry makes a wrapped address stay out of range for the rest of the burst.
    assign {inc_carry, inc_addr} = {1'b0, addr_reg} + (ADDR_W+1)'(1);

    always_comb begin
        addr_next = inc_addr;
        oor_next  = wrap_reg | inc_carry | out_of_range(inc_addr);
        if (state_reg == S_IDLE) begin
            addr_next = sel_start;
            oor_next  = out_of_range(sel_start);
        end
    end

    // gnt is decoded in the arbitration cycle itself; reset_n gating keeps it low during reset.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_gnt
            assign bus.gnt[gi] = reset_n && do_grant && (winner == 1'(gi));
        end
    endgenerate

    always_ff @(posedge clk_pix or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= S_IDLE;
            addr_reg     <= '0;
            rom_addr_reg <= '0;
            cnt_reg      <= '0;
            owner_reg    <= 1'b0;
            oor_reg      <= 1'b0;
            wrap_reg     <= 1'b0;
            rd_valid_reg <= 2'b00;
            rd_last_reg  <= 1'b0;
            err_reg      <= 1'b0;
`ifdef SPRITE_ARB_RR_EN
            last_gnt_reg <= 1'b1;
`endif
        end else begin
            rd_valid_reg <= 2'b00;
            rd_last_reg  <= 1'b0;
            err_reg      <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (any_req) begin
                        state_reg    <= S_BURST;
                        owner_reg    <= winner;
                        cnt_reg      <= sel_len_eff;
                        addr_reg     <= addr_next;
                        oor_reg      <= oor_next;
                        wrap_reg     <= 1'b0;
                        rom_addr_reg <= oor_next ? '0 : addr_next;
`ifdef SPRITE_ARB_RR_EN
                        last_gnt_reg <= winner;
`endif
                    end
                end
                S_BURST: begin
                    // Tag the beat now on rom_addr; it pairs with rom_data one cycle later.
                    rd_valid_reg <= owner_reg ? 2'b10 : 2'b01;
                    rd_last_reg  <= (cnt_reg == LEN_W'(1));
                    err_reg      <= oor_reg;
                    if (cnt_reg == LEN_W'(1)) begin
                        state_reg <= S_IDLE;
                    end else begin
                        cnt_reg      <= cnt_reg - LEN_W'(1);
                        addr_reg     <= addr_next;
                        oor_reg      <= oor_next;
                        wrap_reg     <= wrap_reg | inc_carry;
                        rom_addr_reg <= oor_next ? '0 : addr_next;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign rom_addr     = rom_addr_reg;
    assign bus.busy     = (state_reg == S_BURST);
    assign bus.rd_valid = rd_valid_reg;
    assign bus.rd_last  = rd_last_reg;
    assign bus.err      = err_reg;
    assign bus.rd_data  = ((|rd_valid_reg) && !err_reg) ? rom_data : '0;
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter with a behavioural registered-read ROM.
module tb_sprite_rom_arbiter;
    localparam int ADDR_W = 13;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 6816;
    localparam int LEN_W  = 7;

    logic              clk_pix = 1'b0;
    logic              reset_n = 1'b0;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    int checks = 0;
    int errors = 0;

    sprite_rom_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

    sprite_rom_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .LEN_W(LEN_W)
    ) dut (
        .clk_pix (clk_pix),
        .reset_n (reset_n),
        .bus     (bus),
        .rom_addr(rom_addr),
        .rom_data(rom_data)
    );

    always #5 clk_pix = ~clk_pix;

    function automatic logic [7:0] rom_fn(input logic [12:0] a);
        logic [15:0] t;
        t = {3'b000, a} * 16'd37 + 16'd11;
        return t[7:0];
    endfunction

    always @(posedge clk_pix) rom_data <= rom_fn(rom_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req_fields(input int who, input int start, input int len);
        if (who == 0) begin
            bus.start_addr0 = ADDR_W'(start);
            bus.len0        = LEN_W'(len);
        end else begin
            bus.start_addr1 = ADDR_W'(start);
            bus.len1        = LEN_W'(len);
        end
    endtask

    // Called at the falling edge of the grant cycle; walks the burst and its data return.
    task automatic tail(input int who, input int start, input int len, input bit hold);
        int n;
        int a;
        n = (len == 0) ? 1 : len;
        for (int c = 1; c <= n + 1; c++) begin
            @(negedge clk_pix);
            if (!hold) bus.req[who] = 1'b0;
            if (c <= n) begin
                a = start + c - 1;
                check("rom_addr", 32'(rom_addr), (a >= DEPTH) ? 32'd0 : 32'(a));
                check("busy", 32'(bus.busy), 32'd1);
                check("gnt_in_burst", 32'(bus.gnt), 32'd0);
            end else begin
                check("busy_bubble", 32'(bus.busy), 32'd0);
            end
            if (c >= 2) begin
                a = start + c - 2;
                check("rd_valid", 32'(bus.rd_valid), 32'(1 << who));
                check("rd_data", 32'(bus.rd_data), (a >= DEPTH) ? 32'd0 : 32'(rom_fn(13'(a))));
                check("rd_last", 32'(bus.rd_last), (c == n + 1) ? 32'd1 : 32'd0);
                check("err", 32'(bus.err), (a >= DEPTH) ? 32'd1 : 32'd0);
            end else begin
                check("rd_valid_lat", 32'(bus.rd_valid), 32'd0);
            end
        end
        $display("burst who=%0d start=%0d len=%0d checks=%0d errors=%0d", who, start, len, checks, errors);
    endtask

    task automatic burst(input int who, input int start, input int len, input bit hold);
        @(negedge clk_pix);
        set_req_fields(who, start, len);
        bus.req[who] = 1'b1;
        #1;
        check("gnt", 32'(bus.gnt), 32'(1 << who));
        check("busy_idle", 32'(bus.busy), 32'd0);
        tail(who, start, len, hold);
    endtask

    task automatic pair(input int first);
        int second;
        second = 1 - first;
        @(negedge clk_pix);
        set_req_fields(0, 400, 2);
        set_req_fields(1, 500, 2);
        bus.req = 2'b11;
        #1;
        check("gnt_pair_first", 32'(bus.gnt), 32'(1 << first));
        tail(first, (first == 0) ? 400 : 500, 2, 1'b0);
        #1;
        check("gnt_pair_second", 32'(bus.gnt), 32'(1 << second));
        tail(second, (second == 0) ? 400 : 500, 2, 1'b0);
    endtask

    task automatic check_outputs_clear(input string tag);
        check({tag, "_gnt"}, 32'(bus.gnt), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
        check({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'd0);
        check({tag, "_rd_data"}, 32'(bus.rd_data), 32'd0);
        check({tag, "_rd_last"}, 32'(bus.rd_last), 32'd0);
        check({tag, "_err"}, 32'(bus.err), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req         = 2'b00;
        bus.start_addr0 = '0;
        bus.start_addr1 = '0;
        bus.len0        = '0;
        bus.len1        = '0;
        reset_n         = 1'b0;
        repeat (2) @(negedge clk_pix);
        check_outputs_clear("reset");
        reset_n = 1'b1;

        // Simultaneous requests straight after reset: requester 0 first, then 1.
        pair(0);
        // Both again: round-robin favours 0 after 1 was granted; fixed priority also gives 0.
        pair(0);

        // Single burst of four beats.
        burst(0, 100, 4, 1'b0);

`ifdef SPRITE_ARB_RR_EN
        pair(1);
`else
        pair(0);
`endif

        // Zero length is one beat.
        burst(0, 50, 0, 1'b0);

        // Crossing the end of the ROM.
        burst(1, 6814, 4, 1'b0);

        // Reset at the second beat of a six-beat burst.
        @(negedge clk_pix);
        set_req_fields(0, 200, 6);
        bus.req = 2'b01;
        #1;
        check("gnt_rst_burst", 32'(bus.gnt), 32'd1);
        @(negedge clk_pix);
        bus.req = 2'b00;
        @(negedge clk_pix);
        check("rom_addr_pre_rst", 32'(rom_addr), 32'd201);
        reset_n = 1'b0;
        #1;
        check_outputs_clear("midrst");
        @(negedge clk_pix);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_pix);
            check("post_rst_busy", 32'(bus.busy), 32'd0);
            check("post_rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        end
        burst(1, 600, 3, 1'b0);

        // Requester holds req through completion and is re-granted after the bubble.
        burst(0, 300, 2, 1'b1);
        #1;
        check("gnt_regrant", 32'(bus.gnt), 32'd1);
        tail(0, 300, 2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
